// File: rtl/dw_conv_pe.sv
// dw_conv_pe: depthwise 3x3 convolution processing element.
// Takes one 9-pixel window per accept and multiplies it by a stored signed 3x3
// kernel. It adds a per-channel bias and requantises the sum to an unsigned
// activation, using rounding and a ReLU clamp. Results are queued in a
// first-word fall-through FIFO. A credit check throttles the window generator.
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   window_valid, window    incoming window, packed [8:0], index 3*row+col
//   win_wr_en               PE can accept a window this cycle
//   cfg_start, cfg_valid,   kernel load: start pulse, then weights 0..8
//   cfg_data
//   bias, shift             per-channel bias and requant shift, static in RUN
//   weights_loaded          kernel complete, PE running
//   out_valid, out_data,    FIFO head and pop
//   out_rd_en
module dw_conv_pe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         window_valid,
    input  logic [9*DATA_WIDTH-1:0]      window,
    output logic                         win_wr_en,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    input  logic [DATA_WIDTH-1:0]        cfg_data,
    input  logic signed [ACC_WIDTH-1:0]  bias,
    input  logic [3:0]                   shift,
    output logic                         weights_loaded,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_rd_en
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH + 1;
    localparam int unsigned ROW_W  = PROD_W + 2;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CRD_W  = CNT_W + 1;
    localparam int unsigned REQ_W  = ACC_WIDTH + 1;
    localparam logic signed [REQ_W-1:0] SAT_MAX = REQ_W'((1 << DATA_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] weight_q [9];
    logic signed [DATA_WIDTH-1:0] weight_d [9];
    logic                         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [PROD_W-1:0]     prod_q [9];
    logic signed [PROD_W-1:0]     prod_d [9];
    logic signed [ROW_W-1:0]      row_q [3];
    logic signed [ROW_W-1:0]      row_d [3];
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0]        mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;

    logic [CRD_W-1:0]             credit;
    logic                         accept, push, pop;
    logic signed [REQ_W-1:0]      rq_round, rq_sum, rq_shr;
    logic [DATA_WIDTH-1:0]        rq_res;

    // Pixel is unsigned, so it is zero-extended before the signed multiply.
    function automatic logic signed [PROD_W-1:0] mul(input logic [DATA_WIDTH-1:0] pix,
                                                     input logic signed [DATA_WIDTH-1:0] w);
        return PROD_W'($signed({1'b0, pix})) * PROD_W'(w);
    endfunction

    // Occupied FIFO entries plus in-flight windows; a same-cycle pop earns no credit.
    assign credit    = CRD_W'(count_q) + CRD_W'(v1_q) + CRD_W'(v2_q) + CRD_W'(v3_q);
    assign win_wr_en = (state_q == RUN) && (credit < CRD_W'(FIFO_DEPTH));
    assign accept    = window_valid && win_wr_en;

    assign weights_loaded = (state_q == RUN);
    assign out_valid      = (count_q != '0);
    assign out_data       = mem_q[rd_ptr_q];

    // Kernel-load FSM: cfg_start always restarts the load and wins over cfg_valid.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        weight_d = weight_q;
        if (cfg_start) begin
            state_d = LOAD;
            idx_d   = '0;
        end else if (state_q == LOAD && cfg_valid) begin
            weight_d[idx_q] = $signed(cfg_data);
            if (idx_q == 4'd8) begin
                state_d = RUN;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    // Three-stage MAC pipeline; valid bits advance every cycle.
    always_comb begin
        v1_d = accept;
        v2_d = v1_q;
        v3_d = v2_q;
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = mul(window[i*DATA_WIDTH +: DATA_WIDTH], weight_q[i]);
        end
        for (int r = 0; r < 3; r++) begin
            row_d[r] = ROW_W'(prod_q[3*r]) + ROW_W'(prod_q[3*r+1]) + ROW_W'(prod_q[3*r+2]);
        end
        acc_d = ACC_WIDTH'(row_q[0]) + ACC_WIDTH'(row_q[1]) + ACC_WIDTH'(row_q[2]) + bias;
    end

    // Round-half-up arithmetic shift, then clamp to [0, 2^DATA_WIDTH-1].
    always_comb begin
        rq_round = (shift == 4'd0) ? '0 : (REQ_W'(1) << (shift - 4'd1));
        rq_sum   = REQ_W'(acc_q) + rq_round;
        rq_shr   = rq_sum >>> shift;
        if (rq_shr[REQ_W-1]) begin
            rq_res = '0;
        end else if (rq_shr > SAT_MAX) begin
            rq_res = '1;
        end else begin
            rq_res = rq_shr[DATA_WIDTH-1:0];
        end
    end

    // Output FIFO; pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_comb begin
        push     = v3_q;
        pop      = out_rd_en && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rq_res;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < 9; i++) begin
                weight_q[i] <= '0;
                prod_q[i]   <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                row_q[r] <= '0;
            end
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            weight_q <= weight_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            prod_q   <= prod_d;
            row_q    <= row_d;
            acc_q    <= acc_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_dw_conv_pe.sv
// tb_dw_conv_pe: directed bench for dw_conv_pe. Inputs change 1 ns after the
// rising edge; outputs are sampled at the same point.
module tb_dw_conv_pe;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 24;
    localparam int unsigned FD = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 window_valid;
    logic [9*DW-1:0]      window;
    logic                 win_wr_en;
    logic                 cfg_start;
    logic                 cfg_valid;
    logic [DW-1:0]        cfg_data;
    logic signed [AW-1:0] bias;
    logic [3:0]           shift;
    logic                 weights_loaded;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_rd_en;

    int tests = 0;
    int fails = 0;
    int k;
    int acc_cnt;
    logic [9*DW-1:0] kw;
    logic [9*DW-1:0] win;

    always #5 clock = ~clock;

    dw_conv_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clock          (clock),
        .reset          (reset),
        .window_valid   (window_valid),
        .window         (window),
        .win_wr_en      (win_wr_en),
        .cfg_start      (cfg_start),
        .cfg_valid      (cfg_valid),
        .cfg_data       (cfg_data),
        .bias           (bias),
        .shift          (shift),
        .weights_loaded (weights_loaded),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_rd_en      (out_rd_en)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Nine entries equal to 'all' except the centre (index 4).
    function automatic logic [9*DW-1:0] fill(input logic [DW-1:0] all, input logic [DW-1:0] ctr);
        logic [9*DW-1:0] r;
        for (int i = 0; i < 9; i++) r[i*DW +: DW] = (i == 4) ? ctr : all;
        return r;
    endfunction

    task automatic load_kernel(input logic [9*DW-1:0] w);
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cfg_data = w[i*DW +: DW];
            tick;
        end
        cfg_valid = 1'b0;
    endtask

    // One window through an empty pipeline: checks latency, result, then pops it.
    task automatic apply(input string tag, input logic [9*DW-1:0] w, input logic [DW-1:0] exp);
        window       = w;
        window_valid = 1'b1;
        tick;
        window_valid = 1'b0;
        tick;
        tick;
        chk1({tag, "_early"}, out_valid, 1'b0);
        tick;
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chk8(tag, out_data, exp);
        out_rd_en = 1'b1;
        tick;
        out_rd_en = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        window_valid = 1'b0;
        window       = '0;
        cfg_start    = 1'b0;
        cfg_valid    = 1'b0;
        cfg_data     = '0;
        bias         = '0;
        shift        = 4'd0;
        out_rd_en    = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk1("rst_wr_en", win_wr_en, 1'b0);
        chk1("rst_loaded", weights_loaded, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk8("rst_out_data", out_data, 8'd0);
        reset = 1'b0;

        // Windows offered in IDLE are never accepted
        window       = fill(8'd9, 8'd9);
        window_valid = 1'b1;
        repeat (5) tick;
        chk1("idle_wr_en", win_wr_en, 1'b0);
        chk1("idle_out_valid", out_valid, 1'b0);
        window_valid = 1'b0;

        // Identity kernel
        load_kernel(fill(8'd0, 8'd1));
        chk1("ident_loaded", weights_loaded, 1'b1);
        chk1("ident_wr_en", win_wr_en, 1'b1);
        apply("ident", fill(8'd7, 8'd100), 8'd100);

        // Saturation and rounding with an all-ones kernel
        load_kernel(fill(8'd1, 8'd1));
        shift = 4'd3;
        apply("sat", fill(8'd255, 8'd255), 8'd255);
        shift = 4'd4;
        apply("round", fill(8'd10, 8'd10), 8'd6);

        // Negative clamp and bias
        load_kernel(fill(8'd0, 8'hFF));
        shift = 4'd0;
        bias  = AW'(20);
        apply("neg_clamp", fill(8'd200, 8'd50), 8'd0);
        bias  = AW'(80);
        apply("neg_bias", fill(8'd200, 8'd50), 8'd30);

        // Mixed-sign kernel 1,-2,3,...,9 on pixels 10..90: 450 - 2 = 448, (448+2)>>>2 = 112
        for (int i = 0; i < 9; i++) begin
            kw[i*DW +: DW]  = (i % 2 == 0) ? 8'(i + 1) : 8'(-(i + 1));
            win[i*DW +: DW] = 8'(10 * (i + 1));
        end
        load_kernel(kw);
        bias  = AW'(-2);
        shift = 4'd2;
        apply("mixed", win, 8'd112);

        // Backpressure: hold window_valid with no pops
        load_kernel(fill(8'd0, 8'd1));
        bias         = '0;
        shift        = 4'd0;
        k            = 0;
        window       = fill(8'd0, 8'd10);
        window_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            acc_cnt = (win_wr_en && window_valid) ? 1 : 0;
            tick;
            if (acc_cnt == 1) begin
                k++;
                window = fill(8'd0, 8'(10 + k));
            end
        end
        chki("bp_accepts", k, 8);
        chk1("bp_wr_en_held_low", win_wr_en, 1'b0);
        window_valid = 1'b0;
        chk1("bp_full_out_valid", out_valid, 1'b1);
        chk8("bp_head", out_data, 8'd10);
        out_rd_en = 1'b1;
        tick;
        out_rd_en = 1'b0;
        chk1("bp_credit_back", win_wr_en, 1'b1);
        for (int i = 1; i < 8; i++) begin
            chk8("bp_drain", out_data, 8'(10 + i));
            out_rd_en = 1'b1;
            tick;
            out_rd_en = 1'b0;
        end
        chk1("bp_empty", out_valid, 1'b0);

        // Reconfiguration mid-stream
        window_valid = 1'b1;
        window       = fill(8'd0, 8'd31);
        tick;
        window       = fill(8'd0, 8'd32);
        tick;
        window       = fill(8'd0, 8'd33);
        cfg_start    = 1'b1;
        chk1("rc_wr_en_before", win_wr_en, 1'b1);
        tick;
        cfg_start = 1'b0;
        window    = fill(8'd0, 8'd99);
        chk1("rc_wr_en_drop", win_wr_en, 1'b0);
        chk1("rc_loaded_drop", weights_loaded, 1'b0);
        acc_cnt   = 0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cfg_data = (i == 4) ? 8'd2 : 8'd0;
            if (win_wr_en) acc_cnt++;
            tick;
        end
        cfg_valid = 1'b0;
        chki("rc_no_accept_in_load", acc_cnt, 0);
        chk1("rc_wr_en_back", win_wr_en, 1'b1);
        tick;
        window_valid = 1'b0;
        chk8("rc_old0", out_data, 8'd31);
        out_rd_en = 1'b1;
        tick;
        chk8("rc_old1", out_data, 8'd32);
        tick;
        chk8("rc_old2", out_data, 8'd33);
        tick;
        out_rd_en = 1'b0;
        chk1("rc_new_valid", out_valid, 1'b1);
        chk8("rc_new", out_data, 8'd198);
        out_rd_en = 1'b1;
        tick;
        out_rd_en = 1'b0;
        chk1("rc_empty", out_valid, 1'b0);

        // cfg_start after 5 weights restarts at index 0 and drops a simultaneous cfg_valid
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 8'd5;
        repeat (5) tick;
        cfg_start = 1'b1;
        cfg_data  = 8'd77;
        tick;
        cfg_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cfg_data = (i == 4) ? 8'd3 : 8'd0;
            tick;
            if (i == 7) chk1("rs_not_yet_loaded", weights_loaded, 1'b0);
        end
        cfg_valid = 1'b0;
        chk1("rs_loaded", weights_loaded, 1'b1);
        apply("restart", fill(8'd7, 8'd20), 8'd60);

        // Reset with a window in flight drops it
        window       = fill(8'd0, 8'd50);
        window_valid = 1'b1;
        tick;
        window_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk1("mr_wr_en", win_wr_en, 1'b0);
        chk1("mr_loaded", weights_loaded, 1'b0);
        #1 reset = 1'b0;
        repeat (5) tick;
        chk1("mr_no_output", out_valid, 1'b0);
        chk8("mr_out_data", out_data, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
